// File: rtl/dut_resp_pkg.sv
// Shared types for the DUT-side request responder: FSM state encoding
// and the response holding register layout.
package dut_resp_pkg;

    // Widest response data the holding register can carry; the top-level
    // DATA_W must not exceed this.
    localparam int RSP_DATA_W = 32;

    // Legacy-compatible state encodings, reused by the enum below.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } resp_state_e;

    typedef struct packed {
        logic                  write;
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

    localparam rsp_t RSP_RESET = '{write: 1'b0, rdata: '0, err: 1'b0};

endpackage

// File: rtl/dut_reg_file.sv
// Small register file: one synchronous write port, one combinational
// read port, cleared to zero by the asynchronous reset.
module dut_reg_file #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    // Indices past the last implemented register are never touched.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    endfunction

    assign rdata = idx_ok(raddr) ? mem_q[raddr] : '0;

    // Next register contents: hold, or overwrite the addressed entry.
    always_comb begin
        mem_d = mem_q;
        if (we && idx_ok(waddr)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage update with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/dut_req_responder.sv
// Target end of the bench request/response channel: accepts one read or
// write at a time, services it against the local register file and returns
// a single response, holding it until the initiator takes it.
module dut_req_responder #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic              tb_clk,
    input  logic              tb_rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    import dut_resp_pkg::*;

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W:0]   REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rsp_t              rsp_q, rsp_d;
    // Low only until the first edge after reset release, so the channel
    // reads "not ready" for the whole reset period.
    logic              up_q, up_d;

    logic              accept;
    logic              rf_we;
    logic [IDX_W-1:0]  rf_raddr;
    logic [DATA_W-1:0] rf_rdata;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    assign req_ready = up_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_write = rsp_q.write;
    assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err   = rsp_q.err;

    // Writes land on the accept edge; reads come from the live request in
    // IDLE (single-cycle latency) or from the captured address in WAIT.
    assign rf_we    = accept && req_write && in_range(req_addr);
    assign rf_raddr = (state_q == IDLE) ? req_addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

    dut_reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_reg_file (
        .clk   (tb_clk),
        .rst_n (tb_rst_n),
        .we    (rf_we),
        .waddr (req_addr[IDX_W-1:0]),
        .wdata (req_wdata),
        .raddr (rf_raddr),
        .rdata (rf_rdata)
    );

    // Request/response FSM with read-latency countdown and response capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rsp_d   = rsp_q;
        up_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d = req_addr;
                    if (req_write) begin
                        rsp_d.write = 1'b1;
                        rsp_d.rdata = '0;
                        rsp_d.err   = !in_range(req_addr);
                        state_d     = RESP;
                    end else if (RD_LATENCY == 1) begin
                        rsp_d.write = 1'b0;
                        rsp_d.err   = !in_range(req_addr);
                        rsp_d.rdata = in_range(req_addr) ? RSP_DATA_W'(rf_rdata) : '0;
                        state_d     = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CNT_ONE) begin
                    rsp_d.write = 1'b0;
                    rsp_d.err   = !in_range(addr_q);
                    rsp_d.rdata = in_range(addr_q) ? RSP_DATA_W'(rf_rdata) : '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_d   = RSP_RESET;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear; an in-flight response is dropped.
    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rsp_q   <= RSP_RESET;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rsp_q   <= rsp_d;
            up_q    <= up_d;
        end
    end

endmodule

// File: tb/tb_dut_req_responder.sv
// Directed bench for dut_req_responder: reset values, write/read, response
// backpressure, out-of-range handling, reset during a read, and read latency
// for RD_LATENCY of 1, 2 and 5.
module tb_dut_req_responder;

    logic        tb_clk;
    logic        tb_rst_n;
    logic        req_valid;
    logic        sw_valid;
    logic        req_write;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        req_ready, rsp_valid, rsp_write, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        l1_req_ready, l1_rsp_valid, l1_rsp_write, l1_rsp_err, l1_busy;
    logic [31:0] l1_rsp_rdata;
    logic        l5_req_ready, l5_rsp_valid, l5_rsp_write, l5_rsp_err, l5_busy;
    logic [31:0] l5_rsp_rdata;

    int          total = 0;
    int          bad   = 0;
    int          lat;
    int          lat1, lat5;
    logic        got_write, got_err;
    logic [31:0] got_rdata, got1_rdata, got5_rdata;

    dut_req_responder #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8), .RD_LATENCY(2)) dut (
        .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
    );

    dut_req_responder #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8), .RD_LATENCY(1)) dut_l1 (
        .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
        .req_valid(sw_valid), .req_ready(l1_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(l1_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(l1_rsp_write),
        .rsp_rdata(l1_rsp_rdata), .rsp_err(l1_rsp_err), .busy(l1_busy)
    );

    dut_req_responder #(.DATA_W(32), .ADDR_W(4), .NUM_REGS(8), .RD_LATENCY(5)) dut_l5 (
        .tb_clk(tb_clk), .tb_rst_n(tb_rst_n),
        .req_valid(sw_valid), .req_ready(l5_req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(l5_rsp_valid), .rsp_ready(rsp_ready), .rsp_write(l5_rsp_write),
        .rsp_rdata(l5_rsp_rdata), .rsp_err(l5_rsp_err), .busy(l5_busy)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic sv, input logic wr,
                                 input logic [3:0] a, input logic [31:0] wd);
        req_valid = v;
        sw_valid  = sv;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    // One request on the main instance with rsp_ready already high; records
    // the response fields and the cycles from the accept edge to rsp_valid.
    task automatic transact(input logic wr, input logic [3:0] a, input logic [31:0] wd);
        applyStimulus(1'b1, 1'b0, wr, a, wd);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        got_write = rsp_write;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        tick();
    endtask

    // One request issued to both sweep instances at once.
    task automatic sweepTransact(input logic wr, input logic [3:0] a, input logic [31:0] wd);
        applyStimulus(1'b0, 1'b1, wr, a, wd);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        lat1 = 0;
        lat5 = 0;
        for (int n = 1; n <= 20; n++) begin
            if (l1_rsp_valid === 1'b1 && lat1 == 0) begin
                lat1 = n;
                got1_rdata = l1_rsp_rdata;
            end
            if (l5_rsp_valid === 1'b1 && lat5 == 0) begin
                lat5 = n;
                got5_rdata = l5_rsp_rdata;
            end
            if (lat1 != 0 && lat5 != 0) break;
            tick();
        end
        tick();
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        rsp_ready = 1'b0;
        tb_rst_n  = 1'b0;
        got1_rdata = '0;
        got5_rdata = '0;

        // Reset held for three cycles
        repeat (3) tick();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_write", 32'(rsp_write), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        tb_rst_n = 1'b1;
        tick();
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        // Write then read addr 3
        rsp_ready = 1'b1;
        transact(1'b1, 4'd3, 32'hDEADBEEF);
        checkOutput("wr3_latency", 32'(lat), 32'd1);
        checkOutput("wr3_write", 32'(got_write), 32'd1);
        checkOutput("wr3_err", 32'(got_err), 32'd0);
        checkOutput("wr3_rdata", got_rdata, 32'd0);
        checkOutput("wr3_ready_back", 32'(req_ready), 32'd1);
        transact(1'b0, 4'd3, 32'd0);
        checkOutput("rd3_latency", 32'(lat), 32'd2);
        checkOutput("rd3_write", 32'(got_write), 32'd0);
        checkOutput("rd3_err", 32'(got_err), 32'd0);
        checkOutput("rd3_rdata", got_rdata, 32'hDEADBEEF);

        // Backpressure: response held for three cycles, stray request ignored
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        checkOutput("bp_wait_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_wait_ready", 32'(req_ready), 32'd0);
        tick();
        checkOutput("bp_valid_rise", 32'(rsp_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 4'd3, 32'h00000055);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            checkOutput("bp_hold_write", 32'(rsp_write), 32'd0);
            checkOutput("bp_hold_req_ready", 32'(req_ready), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        rsp_ready = 1'b1;
        tick();
        checkOutput("bp_done_valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp_done_ready", 32'(req_ready), 32'd1);
        tick();
        checkOutput("bp_single_hs", 32'(rsp_valid), 32'd0);
        transact(1'b0, 4'd3, 32'd0);
        checkOutput("bp_stray_ignored", got_rdata, 32'hDEADBEEF);

        // Out-of-range address 9
        transact(1'b1, 4'd9, 32'h00001234);
        checkOutput("oor_wr_latency", 32'(lat), 32'd1);
        checkOutput("oor_wr_err", 32'(got_err), 32'd1);
        checkOutput("oor_wr_rdata", got_rdata, 32'd0);
        transact(1'b0, 4'd9, 32'd0);
        checkOutput("oor_rd_latency", 32'(lat), 32'd2);
        checkOutput("oor_rd_err", 32'(got_err), 32'd1);
        checkOutput("oor_rd_rdata", got_rdata, 32'd0);
        for (int r = 0; r < 8; r++) begin
            transact(1'b0, 4'(r), 32'd0);
            checkOutput($sformatf("regs_after_oor_%0d", r), got_rdata,
                        (r == 3) ? 32'hDEADBEEF : 32'd0);
            checkOutput($sformatf("regs_err_%0d", r), 32'(got_err), 32'd0);
        end

        // Reset asserted while a read is in WAIT
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd3, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
        checkOutput("mid_busy_wait", 32'(busy), 32'd1);
        tb_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("mid_rst_hold_valid", 32'(rsp_valid), 32'd0);
        end
        tb_rst_n = 1'b1;
        tick();
        checkOutput("mid_rst_idle_ready", 32'(req_ready), 32'd1);
        checkOutput("mid_rst_no_valid", 32'(rsp_valid), 32'd0);
        transact(1'b0, 4'd3, 32'd0);
        checkOutput("mid_rst_rd3_latency", 32'(lat), 32'd2);
        checkOutput("mid_rst_rd3_cleared", got_rdata, 32'd0);

        // Latency sweep on the RD_LATENCY=1 and =5 instances
        sweepTransact(1'b1, 4'd2, 32'h0000A5A5);
        checkOutput("sw_l1_wr_latency", 32'(lat1), 32'd1);
        checkOutput("sw_l5_wr_latency", 32'(lat5), 32'd1);
        sweepTransact(1'b0, 4'd2, 32'd0);
        checkOutput("sw_l1_rd_latency", 32'(lat1), 32'd1);
        checkOutput("sw_l1_rd_rdata", got1_rdata, 32'h0000A5A5);
        checkOutput("sw_l5_rd_latency", 32'(lat5), 32'd5);
        checkOutput("sw_l5_rd_rdata", got5_rdata, 32'h0000A5A5);
        checkOutput("sw_l5_idle", 32'(l5_req_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
